cu_mbank_seq: RTL and testbench
===============================

Name: cu_mbank_seq

Overview:
- Parametrised, multi-cycle sequencing control unit for a banked SRAM macro generated by MemGen.
- Accepts one read or write request per operation and latches the address.
- Drives per-bank CK/PRCH/WLE/WEN/SAE strobes through timed phases (precharge, wordline, sense) set by cycle-count parameters. Decodes row and column address.
- Captures read data from the selected bank into a held output register, with a valid pulse and a READY handshake.

Parameters:
- BANKS, 4, number of banks (need not be a power of 2).
- BANKS_BIT_COUNT, 2, bank address bits; must satisfy 2^BANKS_BIT_COUNT >= BANKS.
- ROWS_BIT_COUNT, 7, row address bits.
- CMUX, 4, column mux ratio; equals 2^COLS_BIT_COUNT.
- COLS_BIT_COUNT, 2, column address bits.
- WORD_SIZE, 32, data word width.
- PRCH_CYC, 1, precharge phase length in cycles; range 1..15.
- WL_CYC, 2, wordline phase length in cycles; range 1..15.
- SAE_CYC, 1, sense phase length in cycles (reads only); range 1..15.
- Derived: AW = BANKS_BIT_COUNT + ROWS_BIT_COUNT + COLS_BIT_COUNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- CE  in  1  request strobe; sampled only when READY=1.
- WE  in  1  1 = write, 0 = read; sampled with CE.
- ADDR  in  AW  {bank, row, col}, MSB to LSB.
- DIN_BANK  in  BANKS*WORD_SIZE  per-bank sense-amp data; bank b occupies [b*WORD_SIZE +: WORD_SIZE].
- READY  out  1  high = request can be accepted.
- CK  out  BANKS  per-bank enable, high for the selected bank while an operation is active.
- PRCH  out  BANKS  per-bank precharge, active-high.
- WLE  out  BANKS  per-bank wordline enable.
- WEN  out  BANKS  per-bank write enable.
- SAE  out  BANKS  per-bank sense-amp enable.
- ROW_ADDR  out  ROWS_BIT_COUNT  latched row address.
- CSEL  out  CMUX  one-hot column select.
- DOUT  out  WORD_SIZE  last read data, held.
- DOUT_VALID  out  1  one-cycle pulse when DOUT is updated.

Behaviour:
- Reset (async, all outputs):
  - READY=1, PRCH=all ones, CK=WLE=WEN=SAE=0, CSEL=0, ROW_ADDR=0, DOUT=0, DOUT_VALID=0, state=IDLE.
  - Asserting RST mid-operation clears all strobes immediately, without waiting for a clock edge.
- FSM states: IDLE, PRE, WL, SA.
  - Phase length is tracked by a 4-bit down-counter loaded on each phase entry.
- IDLE:
  - READY=1.
  - On an edge where CE=1, latch ADDR and WE, then go to PRE.
  - CE=0 stays in IDLE.
- PRE: lasts PRCH_CYC cycles, then go to WL.
- WL: lasts WL_CYC cycles.
  - Read: go to SA.
  - Write: go to IDLE.
- SA: lasts SAE_CYC cycles, then go to IDLE.
  - On the exit edge, DOUT <= DIN_BANK slice of the latched bank, and DOUT_VALID=1 for the following cycle.
- Outputs are decoded only from the state register and latched fields, so they are glitch-free. Let sel = the one-hot latched bank.
  - CK = sel in PRE, WL and SA; 0 in IDLE.
  - PRCH = all ones in IDLE. In PRE, all ones. In WL and SA, sel bank = 0 and others = 1.
  - WLE = sel in WL.
  - WEN = sel in WL when write.
  - SAE = sel in SA.
  - CSEL = one-hot of the latched column in PRE, WL and SA; 0 in IDLE.
  - ROW_ADDR = latched row, held until the next accept.
- READY is 0 in all non-IDLE states. A CE or ADDR change while busy is ignored, not queued.
- Latency (edge 0 = accept edge):
  - Read: DOUT valid after edge PRCH_CYC+WL_CYC+SAE_CYC. With defaults, that is edge 4.
  - Back-to-back period = total phases + 1 cycle. Defaults: read 5 cycles, write 4 cycles.
- Out-of-range bank (latched bank >= BANKS):
  - The request is accepted and sequenced normally, but sel=0, so no bank strobes fire.
  - A read loads DOUT=0 with DOUT_VALID=1.
- A write never modifies DOUT.
- DOUT_VALID never asserts for a write.

Test Plan:
- Reset: RST=1 mid-run -> READY=1, PRCH=4'b1111, CK/WLE/WEN/SAE=0, DOUT=0 with no clock edge.
- Read, defaults: ADDR=11'h417 (bank 2, row 5, col 3), CE=1, WE=0, DIN_BANK slice2=32'hDEADBEEF -> the following sequence:
  - ROW_ADDR=5 and CSEL=4'b1000.
  - PRE for 1 cycle, with CK=4'b0100.
  - WLE=4'b0100 for 2 cycles, with PRCH=4'b1011.
  - SAE=4'b0100 for 1 cycle.
  - DOUT=32'hDEADBEEF with DOUT_VALID high for one cycle after edge 4.
- Write: ADDR bank 0, CE=1, WE=1 -> WEN=WLE=4'b0001 for 2 cycles, SAE stays 0, DOUT unchanged, DOUT_VALID=0, READY=1 after edge 3.
- Busy ignore: CE=1 with a new ADDR during WL -> no effect on ROW_ADDR or CSEL, and no second operation.
- Back-to-back reads with CE held high -> accepts spaced exactly 5 cycles apart; DOUT_VALID pulses 5 cycles apart.
- Parameter sweep: PRCH_CYC=3, WL_CYC=1, SAE_CYC=2, BANKS=3 with a bank-3 read -> phase lengths 3/1/2, no bank strobes, DOUT=0 with valid after edge 6.

Source files
------------

// File: rtl/cu_mbank_seq.sv
// Multi-cycle sequencer for a banked SRAM macro: latches one request, walks it
// through precharge / wordline / sense phases and captures read data per bank.
module cu_mbank_seq #(
    parameter int BANKS           = 4,
    parameter int BANKS_BIT_COUNT = 2,
    parameter int ROWS_BIT_COUNT  = 7,
    parameter int CMUX            = 4,
    parameter int COLS_BIT_COUNT  = 2,
    parameter int WORD_SIZE       = 32,
    parameter int PRCH_CYC        = 1,
    parameter int WL_CYC          = 2,
    parameter int SAE_CYC         = 1,
    localparam int AW = BANKS_BIT_COUNT + ROWS_BIT_COUNT + COLS_BIT_COUNT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CE,
    input  logic                       WE,
    input  logic [AW-1:0]              ADDR,
    input  logic [BANKS*WORD_SIZE-1:0] DIN_BANK,
    output logic                       READY,
    output logic [BANKS-1:0]           CK,
    output logic [BANKS-1:0]           PRCH,
    output logic [BANKS-1:0]           WLE,
    output logic [BANKS-1:0]           WEN,
    output logic [BANKS-1:0]           SAE,
    output logic [ROWS_BIT_COUNT-1:0]  ROW_ADDR,
    output logic [CMUX-1:0]            CSEL,
    output logic [WORD_SIZE-1:0]       DOUT,
    output logic                       DOUT_VALID
);

    typedef enum logic [1:0] {IDLE, PRE, WL, SA} state_t;

    state_t                       r_state;
    logic [3:0]                   r_cnt;
    logic [BANKS_BIT_COUNT-1:0]   r_bank;
    logic [ROWS_BIT_COUNT-1:0]    r_row;
    logic [COLS_BIT_COUNT-1:0]    r_col;
    logic                         r_we;
    logic [WORD_SIZE-1:0]         r_dout;
    logic                         r_dout_valid;

    logic [BANKS-1:0]             w_sel;
    logic [CMUX-1:0]              w_col_oh;
    logic [WORD_SIZE-1:0]         w_rd_data;
    logic                         w_phase_done;

    // An out-of-range bank matches no decoder output, so it leaves sel all zero.
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank_dec
        assign w_sel[gi] = (r_bank == BANKS_BIT_COUNT'(gi));
    end

    for (genvar gi = 0; gi < CMUX; gi++) begin : g_col_dec
        assign w_col_oh[gi] = (r_col == COLS_BIT_COUNT'(gi));
    end

    always_comb begin
        w_rd_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_sel[b]) begin
                w_rd_data = DIN_BANK[b*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign w_phase_done = (r_cnt == 4'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bank       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_we         <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (CE) begin
                        r_bank  <= ADDR[AW-1 -: BANKS_BIT_COUNT];
                        r_row   <= ADDR[COLS_BIT_COUNT +: ROWS_BIT_COUNT];
                        r_col   <= ADDR[COLS_BIT_COUNT-1:0];
                        r_we    <= WE;
                        r_cnt   <= 4'(PRCH_CYC - 1);
                        r_state <= PRE;
                    end
                end
                PRE: begin
                    if (w_phase_done) begin
                        r_cnt   <= 4'(WL_CYC - 1);
                        r_state <= WL;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WL: begin
                    if (w_phase_done) begin
                        r_cnt   <= 4'(SAE_CYC - 1);
                        r_state <= r_we ? IDLE : SA;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                SA: begin
                    if (w_phase_done) begin
                        r_dout       <= w_rd_data;
                        r_dout_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes depend only on registered state, so async reset clears them at once.
    always_comb begin
        READY = (r_state == IDLE);
        CK    = '0;
        PRCH  = '1;
        WLE   = '0;
        WEN   = '0;
        SAE   = '0;
        CSEL  = '0;
        case (r_state)
            PRE: begin
                CK   = w_sel;
                CSEL = w_col_oh;
            end
            WL: begin
                CK   = w_sel;
                PRCH = ~w_sel;
                WLE  = w_sel;
                WEN  = r_we ? w_sel : '0;
                CSEL = w_col_oh;
            end
            SA: begin
                CK   = w_sel;
                PRCH = ~w_sel;
                SAE  = w_sel;
                CSEL = w_col_oh;
            end
            default: ;
        endcase
    end

    assign ROW_ADDR   = r_row;
    assign DOUT       = r_dout;
    assign DOUT_VALID = r_dout_valid;

endmodule

// File: tb/tb_cu_mbank_seq.sv
// Bench for cu_mbank_seq: default and swept-parameter instances share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_cu_mbank_seq;

    localparam int MP [2] = '{1, 3};
    localparam int MW [2] = '{2, 1};
    localparam int MS [2] = '{1, 2};
    localparam int MB [2] = '{4, 3};

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ce = 1'b0;
    logic         we = 1'b0;
    logic [10:0]  addr = '0;
    logic [127:0] din = '0;

    logic        rdy0, rdy1, vld0, vld1;
    logic [3:0]  ck0, prch0, wle0, wen0, sae0, csel0, csel1;
    logic [2:0]  ck1, prch1, wle1, wen1, sae1;
    logic [6:0]  row0, row1;
    logic [31:0] dout0, dout1;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    cu_mbank_seq u0 (
        .CLK(CLK), .RST(RST), .CE(ce), .WE(we), .ADDR(addr), .DIN_BANK(din),
        .READY(rdy0), .CK(ck0), .PRCH(prch0), .WLE(wle0), .WEN(wen0), .SAE(sae0),
        .ROW_ADDR(row0), .CSEL(csel0), .DOUT(dout0), .DOUT_VALID(vld0)
    );

    cu_mbank_seq #(.BANKS(3), .PRCH_CYC(3), .WL_CYC(1), .SAE_CYC(2)) u1 (
        .CLK(CLK), .RST(RST), .CE(ce), .WE(we), .ADDR(addr), .DIN_BANK(din[95:0]),
        .READY(rdy1), .CK(ck1), .PRCH(prch1), .WLE(wle1), .WEN(wen1), .SAE(sae1),
        .ROW_ADDR(row1), .CSEL(csel1), .DOUT(dout1), .DOUT_VALID(vld1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Transaction model: an operation is a count of cycles since its accept edge.
    logic        m_busy  [2];
    int          m_c     [2];
    logic [1:0]  m_bank  [2];
    logic [6:0]  m_row   [2];
    logic [1:0]  m_col   [2];
    logic        m_we    [2];
    logic [31:0] m_dout  [2];
    logic        m_valid [2];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_busy[i] <= 1'b0; m_c[i] <= 0; m_bank[i] <= '0; m_row[i] <= '0;
                m_col[i] <= '0; m_we[i] <= 1'b0; m_dout[i] <= '0; m_valid[i] <= 1'b0;
            end else begin
                m_valid[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (ce) begin
                        m_busy[i] <= 1'b1;
                        m_c[i]    <= 0;
                        m_bank[i] <= addr[10:9];
                        m_row[i]  <= addr[8:2];
                        m_col[i]  <= addr[1:0];
                        m_we[i]   <= we;
                    end
                end else if (m_c[i] == MP[i] + MW[i] + (m_we[i] ? 0 : MS[i]) - 1) begin
                    m_busy[i] <= 1'b0;
                    if (!m_we[i]) begin
                        m_dout[i]  <= (int'(m_bank[i]) < MB[i]) ? din[m_bank[i]*32 +: 32] : 32'h0;
                        m_valid[i] <= 1'b1;
                    end
                end else begin
                    m_c[i] <= m_c[i] + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [3:0] sel, mask, e_ck, e_prch, e_wle, e_wen, e_sae, e_csel;
        logic [3:0] a_ck, a_prch, a_wle, a_wen, a_sae, a_csel;
        logic [6:0] a_row;
        logic [31:0] a_dout;
        logic a_rdy, a_vld;
        int ph;
        for (int i = 0; i < 2; i++) begin
            mask = 4'((1 << MB[i]) - 1);
            sel  = (m_busy[i] && int'(m_bank[i]) < MB[i]) ? 4'(1 << m_bank[i]) : 4'h0;
            ph   = !m_busy[i] ? 0 : (m_c[i] < MP[i]) ? 1 : (m_c[i] < MP[i] + MW[i]) ? 2 : 3;
            e_ck   = sel;
            e_prch = (ph >= 2) ? (mask & ~sel) : mask;
            e_wle  = (ph == 2) ? sel : 4'h0;
            e_wen  = (ph == 2 && m_we[i]) ? sel : 4'h0;
            e_sae  = (ph == 3) ? sel : 4'h0;
            e_csel = m_busy[i] ? 4'(1 << m_col[i]) : 4'h0;
            if (i == 0) begin
                a_rdy = rdy0; a_ck = ck0; a_prch = prch0; a_wle = wle0; a_wen = wen0;
                a_sae = sae0; a_csel = csel0; a_row = row0; a_dout = dout0; a_vld = vld0;
            end else begin
                a_rdy = rdy1; a_ck = {1'b0, ck1}; a_prch = {1'b0, prch1}; a_wle = {1'b0, wle1};
                a_wen = {1'b0, wen1}; a_sae = {1'b0, sae1}; a_csel = csel1; a_row = row1;
                a_dout = dout1; a_vld = vld1;
            end
            chk($sformatf("u%0d_ready", i), 32'(a_rdy), 32'(!m_busy[i]));
            chk($sformatf("u%0d_ck", i), 32'(a_ck), 32'(e_ck));
            chk($sformatf("u%0d_prch", i), 32'(a_prch), 32'(e_prch));
            chk($sformatf("u%0d_wle", i), 32'(a_wle), 32'(e_wle));
            chk($sformatf("u%0d_wen", i), 32'(a_wen), 32'(e_wen));
            chk($sformatf("u%0d_sae", i), 32'(a_sae), 32'(e_sae));
            chk($sformatf("u%0d_csel", i), 32'(a_csel), 32'(e_csel));
            chk($sformatf("u%0d_row", i), 32'(a_row), 32'(m_row[i]));
            chk($sformatf("u%0d_dout", i), a_dout, m_dout[i]);
            chk($sformatf("u%0d_valid", i), 32'(a_vld), 32'(m_valid[i]));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            ce = 1'b0;
        end
    endtask

    initial begin
        int vt[$];
        int cyc;
        din = {32'h11111111, 32'hDEADBEEF, 32'h33333333, 32'h44444444};
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_prch", 32'(prch0), 32'hF);
        chk("rst_ck", 32'(ck0), 32'h0);
        #2 RST = 1'b0;
        idle(2);

        // Directed read of bank 2, row 5, col 3
        ce = 1'b1; we = 1'b0; addr = 11'h417;
        @(negedge CLK); ce = 1'b0;
        chk("rd_ck", 32'(ck0), 32'h4);
        chk("rd_csel", 32'(csel0), 32'h8);
        chk("rd_row", 32'(row0), 32'd5);
        chk("rd_pre_prch", 32'(prch0), 32'hF);
        @(negedge CLK);
        chk("rd_wle1", 32'(wle0), 32'h4);
        chk("rd_wl_prch", 32'(prch0), 32'hB);
        @(negedge CLK);
        chk("rd_wle2", 32'(wle0), 32'h4);
        @(negedge CLK);
        chk("rd_sae", 32'(sae0), 32'h4);
        chk("rd_sa_wle", 32'(wle0), 32'h0);
        @(negedge CLK);
        chk("rd_dout", dout0, 32'hDEADBEEF);
        chk("rd_valid", 32'(vld0), 32'd1);
        @(negedge CLK);
        chk("rd_valid_pulse", 32'(vld0), 32'd0);
        @(negedge CLK);
        chk("sw_rd_dout", dout1, 32'hDEADBEEF);
        chk("sw_rd_valid", 32'(vld1), 32'd1);
        idle(3);

        // Directed write to bank 0
        ce = 1'b1; we = 1'b1; addr = 11'h00A;
        @(negedge CLK); ce = 1'b0;
        chk("wr_pre_wen", 32'(wen0), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("wr_wen", 32'(wen0), 32'h1);
            chk("wr_wle", 32'(wle0), 32'h1);
        end
        @(negedge CLK);
        chk("wr_ready", 32'(rdy0), 32'd1);
        chk("wr_sae", 32'(sae0), 32'h0);
        chk("wr_dout", dout0, 32'hDEADBEEF);
        chk("wr_valid", 32'(vld0), 32'd0);
        idle(8);

        // New request presented while busy in WL must be ignored
        ce = 1'b1; we = 1'b0; addr = 11'h417;
        @(negedge CLK); ce = 1'b0;
        @(negedge CLK); ce = 1'b1; addr = 11'h0FF;
        @(negedge CLK);
        chk("busy_row", 32'(row0), 32'd5);
        chk("busy_csel", 32'(csel0), 32'h8);
        @(negedge CLK); ce = 1'b0;
        idle(2);
        chk("busy_no_second", 32'(rdy0), 32'd1);
        idle(6);

        // Out-of-range bank on the 3-bank instance: no strobes, DOUT forced to 0
        ce = 1'b1; we = 1'b0; addr = 11'h617;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); ce = 1'b0;
            chk("sw_strobes", 32'(ck1 | wle1 | wen1 | sae1), 32'h0);
            chk("sw_prch", 32'(prch1), 32'h7);
            chk("sw_busy", 32'(rdy1), 32'd0);
        end
        @(negedge CLK);
        chk("sw_dout0", dout1, 32'h0);
        chk("sw_valid", 32'(vld1), 32'd1);
        idle(4);

        // Back-to-back reads with CE held high
        ce = 1'b1; we = 1'b0; addr = 11'h20D;
        cyc = 0;
        repeat (22) begin
            @(negedge CLK);
            cyc++;
            if (vld0) vt.push_back(cyc);
        end
        ce = 1'b0;
        chk("b2b_count", 32'(vt.size() >= 3), 32'd1);
        for (int k = 1; k < vt.size(); k++) chk("b2b_spacing", 32'(vt[k] - vt[k-1]), 32'd5);
        idle(10);

        // Async reset in the middle of a read
        ce = 1'b1; we = 1'b0; addr = 11'h417;
        @(negedge CLK); ce = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_ready", 32'(rdy0), 32'd1);
        chk("arst_prch", 32'(prch0), 32'hF);
        chk("arst_strobes", 32'(ck0 | wle0 | wen0 | sae0), 32'h0);
        chk("arst_dout", dout0, 32'h0);
        @(negedge CLK);
        #2 RST = 1'b0;
        idle(2);

        // Randomised traffic
        repeat (500) begin
            @(negedge CLK);
            ce   = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 11'($urandom);
            din  = {$urandom, $urandom, $urandom, $urandom};
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
